// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the 12-by-6 restoring divider.
package div_pkg;
  localparam int N_W_DEF = 12;
  localparam int D_W_DEF = 6;
  // Cycles from the accepting start edge to the cycle in which done is high.
  localparam int DIV_LAT = N_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div12by6_step.sv
// One restoring shift-compare-subtract iteration (purely combinational).
module div12by6_step
  import div_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  logic [D_W:0]   prem_i,     // partial remainder before this step
  input  logic           bit_i,      // next dividend bit, MSB first
  input  logic [D_W-1:0] divisor_i,
  output logic [D_W:0]   prem_o,     // partial remainder after this step
  output logic           qbit_o      // quotient bit produced by this step
);
  logic [D_W+1:0] shifted;

  assign shifted = {prem_i, bit_i};

  // Subtract when it does not go negative, otherwise keep the shifted value.
  always_comb begin
    qbit_o = (shifted >= {2'b00, divisor_i});
    prem_o = qbit_o ? (D_W+1)'(shifted - {2'b00, divisor_i}) : shifted[D_W:0];
  end
endmodule

// File: rtl/div12by6.sv
// Multi-cycle unsigned divider: one quotient bit per clock, FSM IDLE/CALC/DONE.
module div12by6
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quot,
  output logic [D_W-1:0] rem,
  output logic           dbz
);
  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_W - 1);

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D_W:0]   prem_q, prem_d;
  // Holds the unconsumed dividend bits in the top, quotient bits shift in below.
  logic [N_W-1:0] shreg_q, shreg_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [D_W:0]   step_prem;
  logic           step_q;

  div12by6_step #(.D_W(D_W)) u_step (
    .prem_i    (prem_q),
    .bit_i     (shreg_q[N_W-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_q)
  );

  // Next-state: accept in IDLE, iterate in CALC, publish results on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shreg_d = shreg_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvs_d   = divisor;
            shreg_d = dividend;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        prem_d  = step_prem;
        shreg_d = {shreg_q[N_W-2:0], step_q};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quot_d  = shreg_d;
          rem_d   = step_prem[D_W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shreg_q <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shreg_q <= shreg_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;
endmodule

// File: doc/div12by6.md
DIV12BY6 -- requirements
Module: div12by6

Interface
REQ-001 Parameter N_W, default 12, dividend and quotient width.
REQ-002 Parameter D_W, default 6, divisor and remainder width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request pulse; operands sampled on the same edge.
REQ-007 dividend  input  N_W  unsigned numerator.
REQ-008 divisor  input  D_W  unsigned denominator.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 quot  output  N_W  unsigned quotient.
REQ-012 rem  output  D_W  unsigned remainder.
REQ-013 dbz  output  1  divide-by-zero flag for the last operation.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE: if start=1 and divisor!=0, SHALL latch operands, clear the iteration counter and go to CALC.
REQ-016 IDLE: if start=1 and divisor=0, SHALL go to DONE with quot=all-ones, rem=0, dbz=1.
REQ-017 CALC SHALL run a restoring shift-subtract algorithm, one quotient bit per cycle, MSB first, for exactly N_W cycles.
REQ-018 Each step SHALL shift a D_W+1-bit partial remainder left by 1 and bring in the next dividend bit.
REQ-019 Each step SHALL subtract the divisor if the result is non-negative and set that quotient bit to 1; otherwise the step SHALL restore and set the bit to 0.
REQ-020 After the N_W-th step the FSM SHALL go to DONE; DONE SHALL last one cycle, then go to IDLE.
REQ-021 Latency: with start sampled at edge k and a nonzero divisor, done SHALL be high in cycle k+N_W+1 (13 for defaults). With divisor 0, done SHALL be high in cycle k+1.
REQ-022 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored, and operands SHALL NOT be resampled.
REQ-024 quot, rem and dbz SHALL update only on entry to DONE and hold until the next accepted operation completes.
REQ-025 For divisor!=0, results SHALL satisfy quot*divisor+rem == dividend and rem < divisor; dbz SHALL be 0.
REQ-026 Input changes outside an accepted start edge SHALL have no effect on results.

Reset
REQ-027 rst_n=0 SHALL, asynchronously and at any time including mid-CALC, force IDLE with busy=0, done=0, quot=0, rem=0, dbz=0, and clear the counter and partial remainder.
REQ-028 An operation aborted by reset SHALL NOT produce done after reset release.
REQ-029 start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package div_pkg SHALL hold N_W/D_W defaults, the state enum (IDLE/CALC/DONE) and the DIV_LAT constant (=N_W+1).
REQ-031 One combinational sub-module, div12by6_step, SHALL implement a single shift-compare-subtract iteration. The top level SHALL hold the FSM, counter and registers.

Verification
REQ-032 Case 1: dividend=100, divisor=7, start one cycle -> done exactly 13 cycles later, quot=14, rem=2, dbz=0.
REQ-033 Case 2: corner cases -> 4095/1 gives quot=4095, rem=0; 4095/63 gives quot=65, rem=0; 5/63 gives quot=0, rem=5; 0/9 gives quot=0, rem=0.
REQ-034 Case 3: divisor=0, dividend=123 -> done next cycle, quot=4095, rem=0, dbz=1; a following 10/3 operation then gives quot=3, rem=1, dbz=0.
REQ-035 Case 4: start 50/5; pulse start with 77/2 at cycle 5 of CALC -> single done, quot=10, rem=0; 77/2 is ignored.
REQ-036 Case 5: start 999/10; assert rst_n=0 at cycle 6 of CALC -> all outputs 0 immediately; no done for 20 cycles after release.
REQ-037 Case 6: exhaustive sweep of all 4096x64 operand pairs -> REQ-025 identity holds for every nonzero divisor, and dbz is set exactly when divisor=0.
